// File: rtl/pipeline_sequencer.sv
// Run/stall/flush sequencer for the 5-stage pipeline: resolves load-use, branch,
// jump and data-memory-wait hazards, with run/halt/step control, drain and timeout.
module pipeline_sequencer #(
  parameter int MEM_TIMEOUT  = 16,
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             step,
  input  logic             halt_req,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             id_jump,
  input  logic             ex_memread,
  input  logic [4:0]       ex_rt,
  input  logic             ex_branch_taken,
  input  logic             mem_access,
  input  logic             mem_ack,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             ctrl_enable,
  output logic             pipe_hold,
  output logic [1:0]       state,
  output logic             mem_error,
  output logic [CNT_W-1:0] stall_count
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RUN     = 2'b01,
    MEMWAIT = 2'b10,
    DRAIN   = 2'b11
  } state_t;

  localparam int WW = $clog2(MEM_TIMEOUT + 1);
  localparam int DW = $clog2(DRAIN_CYCLES + 1);
  localparam logic [WW-1:0] WAIT_LAST  = WW'(MEM_TIMEOUT - 1);
  localparam logic [DW-1:0] DRAIN_INIT = DW'(DRAIN_CYCLES);

  state_t        cur;
  state_t        ret_state;
  logic [DW-1:0] drain_cnt;
  logic [WW-1:0] wait_cnt;
  logic          halt_pend;

  logic freeze;
  logic load_use;
  logic advance;
  logic stall_inc;

  assign freeze   = mem_access & ~mem_ack;
  assign load_use = ex_memread & (ex_rt != 5'd0) &
                    ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));
  // The ack cycle of a memory wait behaves like an ordinary advance.
  assign advance  = (cur == RUN) |
                    ((cur == IDLE) & ~mem_error & ~run & step) |
                    ((cur == MEMWAIT) & mem_ack);
  // A branch flushes ID, so a coincident load-use bubble is not a stall.
  assign stall_inc = advance & (freeze | (~ex_branch_taken & load_use));
  assign state     = cur;

  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch behind.
    pc_write    = 1'b0;
    ifid_write  = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    ctrl_enable = 1'b0;
    pipe_hold   = 1'b1;
    if (advance) begin
      if (freeze) begin
        ctrl_enable = 1'b1;
      end else if (ex_branch_taken) begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b1;
        idex_flush  = 1'b1;
        ctrl_enable = 1'b1;
        pipe_hold   = 1'b0;
      end else if (load_use) begin
        pipe_hold   = 1'b0;
      end else begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = id_jump;
        ctrl_enable = 1'b1;
        pipe_hold   = 1'b0;
      end
    end else if (cur == MEMWAIT) begin
      ctrl_enable = 1'b1;
    end else if (cur == DRAIN && !freeze) begin
      ifid_write  = 1'b1;
      ifid_flush  = 1'b1;
      pipe_hold   = 1'b0;
    end
    if (!rst_n) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ifid_flush  = 1'b0;
      idex_flush  = 1'b0;
      ctrl_enable = 1'b0;
      pipe_hold   = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur         <= IDLE;
      ret_state   <= IDLE;
      drain_cnt   <= '0;
      wait_cnt    <= '0;
      halt_pend   <= 1'b0;
      mem_error   <= 1'b0;
      stall_count <= '0;
    end else begin
      if (stall_inc && stall_count != '1)
        stall_count <= stall_count + CNT_W'(1);
      unique case (cur)
        IDLE: begin
          if (!mem_error) begin
            if (run) begin
              cur <= RUN;
            end else if (step && freeze) begin
              cur       <= MEMWAIT;
              ret_state <= IDLE;
              wait_cnt  <= WW'(1);
            end
          end
        end
        RUN: begin
          if (freeze) begin
            cur       <= MEMWAIT;
            ret_state <= RUN;
            wait_cnt  <= WW'(1);
            if (halt_req) halt_pend <= 1'b1;
          end else if (halt_req || halt_pend) begin
            cur       <= DRAIN;
            drain_cnt <= DRAIN_INIT;
            halt_pend <= 1'b0;
          end
        end
        MEMWAIT: begin
          if (halt_req && ret_state == RUN) halt_pend <= 1'b1;
          if (mem_ack) begin
            cur      <= ret_state;
            wait_cnt <= '0;
          end else if (wait_cnt >= WAIT_LAST) begin
            cur       <= IDLE;
            mem_error <= 1'b1;
            wait_cnt  <= '0;
            halt_pend <= 1'b0;
          end else begin
            wait_cnt <= wait_cnt + WW'(1);
          end
        end
        DRAIN: begin
          // A pending memory access pauses the drain in place.
          if (!freeze) begin
            if (drain_cnt <= DW'(1)) begin
              cur       <= IDLE;
              drain_cnt <= '0;
            end else begin
              drain_cnt <= drain_cnt - DW'(1);
            end
          end
        end
        default: cur <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Directed bench for pipeline_sequencer: a behavioural model checked every
// negedge plus hand-computed literal expectations at key points.
module tb_pipeline_sequencer;

  localparam int CNT_W   = 4;
  localparam int TIMEOUT = 16;
  localparam int DRAIN_N = 3;
  localparam int SAT     = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n, run, step, halt_req;
  logic [4:0]       id_rs, id_rt, ex_rt;
  logic             id_uses_rt, id_jump, ex_memread, ex_branch_taken;
  logic             mem_access, mem_ack;
  logic             pc_write, ifid_write, ifid_flush, idex_flush;
  logic             ctrl_enable, pipe_hold, mem_error;
  logic [1:0]       state;
  logic [CNT_W-1:0] stall_count;

  int n_vec = 0;
  int n_bad = 0;

  // Model: mode 0 idle, 1 run, 2 waiting on memory, 3 draining.
  logic [1:0] m_mode = 2'd0;
  logic [1:0] m_ret  = 2'd0;
  int         m_left = 0;
  int         m_wait = 0;
  bit         m_err  = 1'b0;
  bit         m_halt = 1'b0;
  int         m_stalls = 0;

  pipeline_sequencer #(.MEM_TIMEOUT(TIMEOUT), .DRAIN_CYCLES(DRAIN_N), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .step(step), .halt_req(halt_req),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt), .id_jump(id_jump),
    .ex_memread(ex_memread), .ex_rt(ex_rt), .ex_branch_taken(ex_branch_taken),
    .mem_access(mem_access), .mem_ack(mem_ack),
    .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
    .idex_flush(idex_flush), .ctrl_enable(ctrl_enable), .pipe_hold(pipe_hold),
    .state(state), .mem_error(mem_error), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit hazard();
    return ex_memread && ex_rt != 0 &&
           (ex_rt == id_rs || (id_uses_rt && ex_rt == id_rt));
  endfunction

  function automatic bit advancing();
    return (m_mode == 2'd1) || (m_mode == 2'd0 && !m_err && !run && step) ||
           (m_mode == 2'd2 && mem_ack);
  endfunction

  // {pc_write, ifid_write, ifid_flush, idex_flush, ctrl_enable, pipe_hold}
  function automatic logic [5:0] expect_ctl();
    bit pend = mem_access && !mem_ack;
    if (!rst_n) return 6'b000001;
    if (advancing()) begin
      if (pend)            return 6'b000011;
      if (ex_branch_taken) return 6'b111110;
      if (hazard())        return 6'b000000;
      if (id_jump)         return 6'b111010;
      return 6'b110010;
    end
    if (m_mode == 2'd2)         return 6'b000011;
    if (m_mode == 2'd3 && !pend) return 6'b011000;
    return 6'b000001;
  endfunction

  task automatic model_step();
    bit pend = mem_access && !mem_ack;
    if (advancing() && (pend || (hazard() && !ex_branch_taken)) && m_stalls < SAT)
      m_stalls++;
    case (m_mode)
      2'd0: if (!m_err) begin
        if (run) m_mode = 2'd1;
        else if (step && pend) begin m_mode = 2'd2; m_ret = 2'd0; m_wait = 1; end
      end
      2'd1: if (pend) begin
        m_mode = 2'd2; m_ret = 2'd1; m_wait = 1;
        if (halt_req) m_halt = 1'b1;
      end else if (halt_req || m_halt) begin
        m_mode = 2'd3; m_left = DRAIN_N; m_halt = 1'b0;
      end
      2'd2: begin
        if (halt_req && m_ret == 2'd1) m_halt = 1'b1;
        if (mem_ack) m_mode = m_ret;
        else begin
          m_wait++;
          if (m_wait >= TIMEOUT) begin m_err = 1'b1; m_mode = 2'd0; m_halt = 1'b0; end
        end
      end
      default: if (!pend) begin
        m_left--;
        if (m_left == 0) m_mode = 2'd0;
      end
    endcase
  endtask

  // Inputs settle by +3 after each posedge, so negedge sees the cycle's final inputs.
  always @(negedge clk) begin
    if (!rst_n) begin
      m_mode = 2'd0; m_ret = 2'd0; m_left = 0; m_wait = 0;
      m_err = 1'b0; m_halt = 1'b0; m_stalls = 0;
    end
    check("cycle",
          {19'd0, pc_write, ifid_write, ifid_flush, idex_flush, ctrl_enable, pipe_hold,
           state, mem_error, stall_count},
          {19'd0, expect_ctl(), m_mode, m_err, CNT_W'(m_stalls)});
    if (rst_n) model_step();
  end

  task automatic go();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    id_rs = 5'd0; id_rt = 5'd0; ex_rt = 5'd0; id_uses_rt = 1'b0; id_jump = 1'b0;
    ex_memread = 1'b0; ex_branch_taken = 1'b0; mem_access = 1'b0; mem_ack = 1'b0;
    halt_req = 1'b0;
  endtask

  initial begin
    clr(); run = 1'b0; step = 1'b1; rst_n = 1'b0;
    go(); go(); #2;
    check("rst_state", state, 0);
    check("rst_hold", pipe_hold, 1);
    check("rst_pc_step_ignored", pc_write, 0);
    check("rst_cnt", stall_count, 0);

    go(); rst_n = 1'b1; step = 1'b0; #2;
    check("idle_pc", pc_write, 0);
    check("idle_ctrl", ctrl_enable, 0);
    go(); run = 1'b1; #2;
    check("run_cycle_no_adv", pc_write, 0);
    go(); run = 1'b0; #2;
    check("run_state", state, 1);
    check("run_pc", pc_write, 1);
    check("run_hold", pipe_hold, 0);

    go(); ex_memread = 1'b1; ex_rt = 5'd5; id_rs = 5'd5; #2;
    check("lu_pc", pc_write, 0);
    check("lu_ifid", ifid_write, 0);
    check("lu_ctrl", ctrl_enable, 0);
    go(); ex_rt = 5'd0; id_rs = 5'd0; #2;
    check("lu_cnt", stall_count, 1);
    check("lu_r0_pc", pc_write, 1);
    go(); ex_rt = 5'd7; id_rs = 5'd3; id_rt = 5'd7; id_uses_rt = 1'b1; #2;
    check("lu_rt_pc", pc_write, 0);
    go(); id_uses_rt = 1'b0; #2;
    check("lu_rt_unused_pc", pc_write, 1);
    check("lu_rt_cnt", stall_count, 2);
    go(); ex_rt = 5'd5; id_rs = 5'd5; ex_branch_taken = 1'b1; #2;
    check("br_ifid_flush", ifid_flush, 1);
    check("br_idex_flush", idex_flush, 1);
    check("br_pc", pc_write, 1);
    go(); clr(); id_jump = 1'b1; #2;
    check("br_cnt_same", stall_count, 2);
    check("j_flush", ifid_flush, 1);
    check("j_idex", idex_flush, 0);

    go(); clr(); mem_access = 1'b1; #2;
    check("mf_state", state, 1);
    check("mf_pc", pc_write, 0);
    check("mf_hold", pipe_hold, 1);
    go(); #2;
    check("mw1_state", state, 2);
    check("mw1_cnt", stall_count, 3);
    go(); halt_req = 1'b1; #2;
    check("mw2_state", state, 2);
    go(); halt_req = 1'b0; #2;
    check("mw3_hold", pipe_hold, 1);
    go(); mem_ack = 1'b1; #2;
    check("mw4_state", state, 2);
    check("mw4_ack_pc", pc_write, 1);
    go(); clr(); #2;
    check("ret_state", state, 1);
    check("ret_cnt", stall_count, 3);
    go(); #2;
    check("dr1_state", state, 3);
    check("dr1_flush", ifid_flush, 1);
    check("dr1_ctrl", ctrl_enable, 0);
    go(); mem_access = 1'b1; #2;
    check("dr_frz_hold", pipe_hold, 1);
    check("dr_frz_ifid", ifid_write, 0);
    go(); clr(); #2;
    check("dr2_state", state, 3);
    go(); #2;
    check("dr3_state", state, 3);
    go(); #2;
    check("dr_done_state", state, 0);
    check("dr_done_pc", pc_write, 0);

    go(); step = 1'b1; id_jump = 1'b1; #2;
    check("step_pc", pc_write, 1);
    check("step_flush", ifid_flush, 1);
    go(); step = 1'b0; clr(); #2;
    check("step_state", state, 0);
    check("step_after_pc", pc_write, 0);

    go(); run = 1'b1;
    go(); run = 1'b0; halt_req = 1'b1; #2;
    check("halt_pc", pc_write, 1);
    go(); halt_req = 1'b0; #2;
    check("halt_drain", state, 3);
    go(); rst_n = 1'b0; #2;
    check("mid_rst_state", state, 0);
    check("mid_rst_flush", ifid_flush, 0);
    check("mid_rst_hold", pipe_hold, 1);

    go(); rst_n = 1'b1; run = 1'b1;
    go(); run = 1'b0;
    go(); mem_access = 1'b1;
    repeat (15) go();
    #2;
    check("to15_state", state, 2);
    check("to15_err", mem_error, 0);
    go(); #2;
    check("to16_state", state, 0);
    check("to16_err", mem_error, 1);
    check("to_cnt", stall_count, 1);
    go(); clr(); run = 1'b1;
    go(); run = 1'b0; #2;
    check("err_run_blocked", state, 0);
    go(); step = 1'b1; id_jump = 1'b1; #2;
    check("err_step_blocked", pc_write, 0);

    go(); clr(); step = 1'b0; rst_n = 1'b0;
    go(); rst_n = 1'b1; run = 1'b1;
    go(); run = 1'b0; ex_memread = 1'b1; ex_rt = 5'd9; id_rs = 5'd9;
    repeat (14) go();
    #2;
    check("sat_14", stall_count, 14);
    go(); #2;
    check("sat_15", stall_count, SAT);
    repeat (5) go();
    #2;
    check("sat_hold", stall_count, SAT);

    go(); clr();
    go();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
